pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It turns the hazard unit's per-cycle `stall` / `flush` requests, the data-memory ready handshake and a retiring halt into enable/clear strobes for the PC and the four pipeline registers (F/D, D/E, E/M, M/W). It also owns reset bubble-fill, memory-wait freezing with a timeout watchdog, and saturating performance counters. It sits beside the hazard unit; every stage register and the PC register take their enable/clear from this block.

## Interface
- `BOOT_CYCLES`, 2: bubble-fill cycles after reset release (≥1).
- `MEM_TIMEOUT`, 64: consecutive frozen cycles before `mem_timeout` is set.
- `CNT_W`, 32: performance counter width.
- `clk` in 1: the single clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `stall` in 1: load-use stall request from the hazard unit.
- `flush` in 1: taken branch/jump flush request from the hazard unit.
- `mem_req_m` in 1: the M-stage instruction accesses data memory this cycle.
- `mem_ready_m` in 1: data memory completes the access this cycle.
- `halt_w` in 1: a halt instruction (ecall/ebreak) is retiring in W.
- `cnt_clear` in 1: synchronous clear of all performance counters.
- `en_pc`, `en_fd`, `en_de`, `en_em`, `en_mw` out 1 each: register load enables.
- `clr_fd`, `clr_de`, `clr_em`, `clr_mw` out 1 each: synchronous bubble insert (load NOP) into that register; only meaningful with its enable high.
- `halted` out 1: core halted.
- `mem_timeout` out 1: sticky watchdog flag.
- `stall_cnt`, `flush_cnt`, `wait_cnt` out CNT_W each: cycles spent in load-use stall, flush and memory freeze.

## Operation
- FSM states: BOOT, RUN, MEM_WAIT, HALTED.
- **BOOT** (entered on reset):
  - Outputs: `en_pc`=0; all stage enables =1; all four clears =1.
  - A down-counter loaded with BOOT_CYCLES-1 moves the FSM to RUN when it reaches 0.
- **RUN / MEM_WAIT**: outputs come from the rules below, in priority order.
  1. Freeze when `mem_req_m && !mem_ready_m`: all enables 0, all clears 0. Next state is MEM_WAIT.
  2. Otherwise, `flush`: all enables 1, `clr_fd`=`clr_de`=1. `stall` is ignored because the stalled instruction is squashed.
  3. Otherwise, `stall`: `en_pc`=`en_fd`=0; `en_de`=`en_em`=`en_mw`=1; `clr_de`=1.
  4. Otherwise: all enables 1, no clears.
- Whenever rule 1 does not fire, the next state is RUN.
- **Halt**: `halt_w` in RUN or MEM_WAIT, when rule 1 is not active, lets W complete this cycle. Next state is HALTED.
- **HALTED**: all enables 0, clears 0, `halted`=1. Only `rst` leaves this state.
- **Watchdog**:
  - `wait_timer` increments each frozen cycle and clears on any non-frozen cycle.
  - Reaching MEM_TIMEOUT sets `mem_timeout`, which holds until `rst`.
  - The freeze continues; the watchdog never releases the pipeline.
- **Counters**:
  - Each counter increments by 1 in cycles where its rule (3, 2 or 1) applies, and only in RUN/MEM_WAIT.
  - Counters saturate at all-ones.
  - `cnt_clear` wins over increment.
- **Reset mid-operation**: asserting `rst` immediately causes:
  - state = BOOT;
  - BOOT outputs;
  - counters, timers, `mem_timeout` and `halted` = 0.
- **Reset values**: `en_pc`=0, `en_fd`..`en_mw`=1, `clr_*`=1, `halted`=0, `mem_timeout`=0, counters 0.

## Timing
- Outputs are Mealy: combinational from the registered state and the current inputs, with zero-cycle latency. A stall/flush/freeze affects the register update at the same clock edge.
- Memory handshake: the cycle in which `mem_ready_m`=1 is a normal advancing cycle under rules 2–4. Wait length equals the number of cycles with `req && !ready`.
- BOOT lasts exactly BOOT_CYCLES cycles after `rst` deassertion. The first RUN cycle is BOOT_CYCLES+1.
- `mem_timeout` rises on the edge ending the MEM_TIMEOUT-th consecutive frozen cycle.
- Simultaneous events:
  - freeze with flush/stall/halt: freeze wins; the other inputs are re-sampled after ready.
  - `flush` with `halt_w`: flush strobes are applied, then HALTED.

## Structure
- `pipe_ctrl_pkg` holds:
  - `pipe_state_t` enum (BOOT, RUN, MEM_WAIT, HALTED);
  - `stage_ctrl_t` packed struct of the 5 enables and 4 clears;
  - NOP-insertion constants shared with the stage registers.
- Sub-module `sat_counter` (parameter W; `clk`, `rst`, `clr`, `inc`, `q`), instantiated three times.
- The watchdog timer and BOOT counter are inline.

## Test plan
- Reset release with BOOT_CYCLES=2 → `en_pc`=0 and all clears =1 for exactly 2 cycles; cycle 3 has all enables 1 and no clears.
- `stall`=1 for one cycle in RUN → `en_pc`=`en_fd`=0 and `clr_de`=1 that cycle; `stall_cnt` goes from 0 to 1.
- `stall`=1 and `flush`=1 together → `clr_fd`=`clr_de`=1 and all enables 1; `flush_cnt`=1 and `stall_cnt`=0.
- `mem_req_m`=1 with `mem_ready_m`=0 for 3 cycles, then ready=1 → all enables 0 for 3 cycles; advance on cycle 4; `wait_cnt`=3; state returns to RUN.
- MEM_TIMEOUT=4 with ready held low for 6 cycles → `mem_timeout`=1 after the 4th frozen cycle and still 1 after ready; pipeline stays frozen until ready.
- `halt_w` pulse, then `rst` pulse mid-HALTED → `halted`=1 and enables 0 from the next cycle; `rst` immediately gives BOOT outputs with `halted`=0 and counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller and the stage registers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StMemWait,
        StHalted
    } pipe_state_t;

    typedef struct packed {
        logic en_pc;
        logic en_fd;
        logic en_de;
        logic en_em;
        logic en_mw;
        logic clr_fd;
        logic clr_de;
        logic clr_em;
        logic clr_mw;
    } stage_ctrl_t;

    // Bubble loaded by a stage register when its clear is taken: addi x0, x0, 0.
    localparam logic [31:0] NopInsn = 32'h0000_0013;
    localparam logic [4:0]  NopRd   = 5'd0;

    localparam stage_ctrl_t CtrlBoot = '{en_pc: 1'b0, en_fd: 1'b1, en_de: 1'b1, en_em: 1'b1,
                                         en_mw: 1'b1, clr_fd: 1'b1, clr_de: 1'b1,
                                         clr_em: 1'b1, clr_mw: 1'b1};
    localparam stage_ctrl_t CtrlRun = '{en_pc: 1'b1, en_fd: 1'b1, en_de: 1'b1, en_em: 1'b1,
                                        en_mw: 1'b1, default: 1'b0};
    localparam stage_ctrl_t CtrlFlush = '{en_pc: 1'b1, en_fd: 1'b1, en_de: 1'b1, en_em: 1'b1,
                                          en_mw: 1'b1, clr_fd: 1'b1, clr_de: 1'b1,
                                          default: 1'b0};
    localparam stage_ctrl_t CtrlStall = '{en_de: 1'b1, en_em: 1'b1, en_mw: 1'b1,
                                          clr_de: 1'b1, default: 1'b0};
    localparam stage_ctrl_t CtrlHold = '{default: 1'b0};

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns hazard/memory/halt events into PC and stage
// register enable/clear strobes, with boot bubble-fill, a freeze watchdog and perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_req_m,
    input  logic             mem_ready_m,
    input  logic             halt_w,
    input  logic             cnt_clear,
    output logic             en_pc,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             clr_fd,
    output logic             clr_de,
    output logic             clr_em,
    output logic             clr_mw,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BW-1:0] BootInit    = BW'(BOOT_CYCLES - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(MEM_TIMEOUT - 1);
    localparam logic [TW-1:0] TimeoutMax  = TW'(MEM_TIMEOUT);

    pipe_state_t   state_q;
    logic [BW-1:0] boot_cnt_q;
    logic [TW-1:0] wait_timer_q;
    logic          mem_timeout_q;

    stage_ctrl_t ctrl;
    logic        frozen, active, stall_inc, flush_inc, wait_inc;

    assign frozen = mem_req_m && !mem_ready_m;
    assign active = (state_q == StRun) || (state_q == StMemWait);

    always_comb begin
        ctrl = CtrlHold;
        unique case (state_q)
            StBoot:           ctrl = CtrlBoot;
            StRun, StMemWait: begin
                if (frozen)     ctrl = CtrlHold;
                else if (flush) ctrl = CtrlFlush;
                else if (stall) ctrl = CtrlStall;
                else            ctrl = CtrlRun;
            end
            StHalted:         ctrl = CtrlHold;
            default:          ctrl = CtrlBoot;
        endcase
    end

    // A flush squashes the stalled instruction, so stall only counts when flush is low.
    assign stall_inc = active && !frozen && !flush && stall;
    assign flush_inc = active && !frozen && flush;
    assign wait_inc  = active && frozen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StBoot;
            boot_cnt_q    <= BootInit;
            wait_timer_q  <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    if (boot_cnt_q == '0) state_q <= StRun;
                    else                  boot_cnt_q <= boot_cnt_q - BW'(1);
                end
                StRun, StMemWait: begin
                    if (frozen)      state_q <= StMemWait;
                    else if (halt_w) state_q <= StHalted;
                    else             state_q <= StRun;
                end
                StHalted: state_q <= StHalted;
                default:  state_q <= StBoot;
            endcase

            // Watchdog only flags; the freeze is never released by it.
            if (wait_inc) begin
                if (wait_timer_q != TimeoutMax) wait_timer_q <= wait_timer_q + TW'(1);
                if (wait_timer_q == TimeoutLast) mem_timeout_q <= 1'b1;
            end else begin
                wait_timer_q <= '0;
            end
        end
    end

    assign en_pc       = ctrl.en_pc;
    assign en_fd       = ctrl.en_fd;
    assign en_de       = ctrl.en_de;
    assign en_em       = ctrl.en_em;
    assign en_mw       = ctrl.en_mw;
    assign clr_fd      = ctrl.clr_fd;
    assign clr_de      = ctrl.clr_de;
    assign clr_em      = ctrl.clr_em;
    assign clr_mw      = ctrl.clr_mw;
    assign halted      = (state_q == StHalted);
    assign mem_timeout = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clear),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clear),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clear),
        .inc (wait_inc),
        .q   (wait_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: boot, stall/flush priority, memory freeze, watchdog,
// counter saturation/clear, halt and reset out of HALTED.
module tb_pipe_ctrl;

    localparam int unsigned CNT_W = 4;

    // {en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw}
    localparam logic [8:0] SBoot   = 9'b0_1111_1111;
    localparam logic [8:0] SRun    = 9'b1_1111_0000;
    localparam logic [8:0] SFlush  = 9'b1_1111_1100;
    localparam logic [8:0] SStall  = 9'b0_0111_0100;
    localparam logic [8:0] SFrozen = 9'b0_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0, flush = 1'b0, mem_req_m = 1'b0, mem_ready_m = 1'b0;
    logic halt_w = 1'b0, cnt_clear = 1'b0;
    logic en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw;
    logic halted, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
    logic [8:0] strobes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .BOOT_CYCLES (2),
        .MEM_TIMEOUT (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .mem_req_m   (mem_req_m),
        .mem_ready_m (mem_ready_m),
        .halt_w      (halt_w),
        .cnt_clear   (cnt_clear),
        .en_pc       (en_pc),
        .en_fd       (en_fd),
        .en_de       (en_de),
        .en_em       (en_em),
        .en_mw       (en_mw),
        .clr_fd      (clr_fd),
        .clr_de      (clr_de),
        .clr_em      (clr_em),
        .clr_mw      (clr_mw),
        .halted      (halted),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .wait_cnt    (wait_cnt)
    );

    assign strobes = {en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the falling edge, then sample 1 time unit later.
    task automatic drive(input logic s, input logic f, input logic req, input logic rdy,
                         input logic h, input logic clr);
        @(negedge clk);
        stall = s; flush = f; mem_req_m = req; mem_ready_m = rdy; halt_w = h; cnt_clear = clr;
        #1;
    endtask

    initial begin
        #1;
        check("reset_strobes", 32'(strobes), 32'(SBoot));
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        check("reset_counters", {20'd0, stall_cnt, flush_cnt, wait_cnt}, 32'd0);
        repeat (2) @(negedge clk);

        @(negedge clk); rst = 1'b0; #1;
        check("boot_cycle1", 32'(strobes), 32'(SBoot));
        drive(0, 0, 0, 0, 0, 0);
        check("boot_cycle2", 32'(strobes), 32'(SBoot));
        drive(0, 0, 0, 0, 0, 0);
        check("boot_cycle3_run", 32'(strobes), 32'(SRun));

        drive(1, 0, 0, 0, 0, 0);
        check("stall_strobes", 32'(strobes), 32'(SStall));
        check("stall_cnt_before", 32'(stall_cnt), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        check("stall_cnt_after", 32'(stall_cnt), 32'd1);
        check("run_after_stall", 32'(strobes), 32'(SRun));

        drive(1, 1, 0, 0, 0, 0);
        check("stall_flush_strobes", 32'(strobes), 32'(SFlush));
        drive(0, 0, 0, 0, 0, 0);
        check("flush_cnt", 32'(flush_cnt), 32'd1);
        check("stall_cnt_unchanged", 32'(stall_cnt), 32'd1);

        // Three frozen cycles with competing requests, then ready.
        drive(1, 1, 1, 0, 1, 0);
        check("freeze1_wins", 32'(strobes), 32'(SFrozen));
        drive(0, 0, 1, 0, 0, 0);
        check("freeze2", 32'(strobes), 32'(SFrozen));
        drive(0, 0, 1, 0, 0, 0);
        check("freeze3", 32'(strobes), 32'(SFrozen));
        drive(0, 0, 1, 1, 0, 0);
        check("ready_advances", 32'(strobes), 32'(SRun));
        check("wait_cnt_3", 32'(wait_cnt), 32'd3);
        check("no_timeout_at_3", 32'(mem_timeout), 32'd0);
        check("freeze_halt_ignored", 32'(halted), 32'd0);
        check("freeze_not_counted", {stall_cnt, flush_cnt}, {24'd0, 4'd1, 4'd1});
        drive(1, 0, 0, 0, 0, 0);
        check("back_in_run_stall", 32'(strobes), 32'(SStall));
        drive(0, 0, 0, 0, 0, 0);

        // Watchdog: flag rises on the edge ending the 4th frozen cycle.
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            check($sformatf("wd_frozen%0d", i), 32'(strobes), 32'(SFrozen));
            check($sformatf("wd_flag%0d", i), 32'(mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 1, 1, 0, 0);
        check("wd_ready_advances", 32'(strobes), 32'(SRun));
        drive(0, 0, 0, 0, 0, 0);
        check("wd_sticky", 32'(mem_timeout), 32'd1);
        check("wait_cnt_9", 32'(wait_cnt), 32'd9);

        // 2 + 16 more stall cycles would overflow a 4-bit counter.
        for (int i = 0; i < 16; i++) drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("stall_cnt_saturated", 32'(stall_cnt), 32'd15);

        drive(1, 1, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        check("cnt_clear_wins", {20'd0, stall_cnt, flush_cnt, wait_cnt}, 32'd0);

        drive(0, 1, 0, 0, 1, 0);
        check("flush_halt_strobes", 32'(strobes), 32'(SFlush));
        check("not_yet_halted", 32'(halted), 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        check("halted_flag", 32'(halted), 32'd1);
        check("halted_strobes", 32'(strobes), 32'(SFrozen));
        check("flush_cnt_before_halt", 32'(flush_cnt), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        check("halted_stall_not_counted", 32'(stall_cnt), 32'd0);
        check("still_halted", 32'(halted), 32'd1);

        // Asynchronous reset mid-HALTED.
        #1 rst = 1'b1; #1;
        check("rst_strobes", 32'(strobes), 32'(SBoot));
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        check("rst_counters", {20'd0, stall_cnt, flush_cnt, wait_cnt}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        check("reboot_cycle1", 32'(strobes), 32'(SBoot));
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("reboot_run", 32'(strobes), 32'(SRun));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
